// File: rtl/qpsk_pkg.sv
// Shared widths, saturation limits and the output clamp for the Farrow interpolator.
package qpsk_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 15;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned UK_W   = 16;
  localparam int unsigned U_W    = FRAC_W + 2;
  localparam int unsigned PROD_W = ACC_W + U_W;
  // Tap sums reach +/-6*32768 before the halving shift.
  localparam int unsigned SUM_W  = DATA_W + 3;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  // Clamp an accumulator value into the Q1.15 output range.
  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'(SAT_MAX);
    lo = ACC_W'(SAT_MIN);
    if (v > hi) begin
      sat_data = DATA_W'(SAT_MAX);
    end else if (v < lo) begin
      sat_data = DATA_W'(SAT_MIN);
    end else begin
      sat_data = DATA_W'(v);
    end
  endfunction

endpackage

// File: rtl/farrow_mac.sv
// Registered multiply-shift-add step of the Horner evaluation: y <= ((a*u) >>> FRAC_W) + b.
module farrow_mac
  import qpsk_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [ACC_W-1:0]  i_a,
  input  logic signed [U_W-1:0]    i_u,
  input  logic signed [ACC_W-1:0]  i_b,
  output logic signed [ACC_W-1:0]  o_y
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;

  // Full-width product, so the multiply itself can never overflow.
  assign w_prod = PROD_W'(i_a) * PROD_W'(i_u);
  assign w_sum  = ACC_W'(w_prod >>> FRAC_W) + i_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_y <= '0;
    end else begin
      o_y <= w_sum;
    end
  end

endmodule

// File: rtl/farrow_interp.sv
// Piecewise-parabolic (alpha=0.5) Farrow interpolator: 4-tap delay line,
// coefficient stage, two Horner MAC stages and a saturating output stage.
module farrow_interp
  import qpsk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              strobe_flag,
  input  logic [UK_W-1:0]   uk,
  output logic [DATA_W-1:0] interp_out,
  output logic              interp_valid
);

  logic signed [DATA_W-1:0] r_x0;
  logic signed [DATA_W-1:0] r_x1;
  logic signed [DATA_W-1:0] r_x2;
  logic signed [DATA_W-1:0] r_x3;

  logic signed [SUM_W-1:0]  w_x0e;
  logic signed [SUM_W-1:0]  w_x1e;
  logic signed [SUM_W-1:0]  w_x2e;
  logic signed [SUM_W-1:0]  w_x3e;
  logic signed [SUM_W-1:0]  w_f1_sum;
  logic signed [SUM_W-1:0]  w_f2_sum;
  logic signed [ACC_W-1:0]  w_f1;
  logic signed [ACC_W-1:0]  w_f2;
  logic signed [ACC_W-1:0]  w_f3;
  logic signed [U_W-1:0]    w_u;
  logic                     w_uk_unused;

  logic signed [ACC_W-1:0]  r_f1;
  logic signed [ACC_W-1:0]  r_f2;
  logic signed [ACC_W-1:0]  r_f3;
  logic signed [U_W-1:0]    r_u1;
  logic                     r_v1;

  logic signed [ACC_W-1:0]  w_p1;
  logic signed [ACC_W-1:0]  r_f3_2;
  logic signed [U_W-1:0]    r_u2;
  logic                     r_v2;

  logic signed [ACC_W-1:0]  w_p2;
  logic                     r_v3;

  // Delay line, x0 newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_x3 <= '0;
    end else begin
      r_x0 <= din;
      r_x1 <= r_x0;
      r_x2 <= r_x1;
      r_x3 <= r_x2;
    end
  end

  assign w_x0e = SUM_W'(r_x0);
  assign w_x1e = SUM_W'(r_x1);
  assign w_x2e = SUM_W'(r_x2);
  assign w_x3e = SUM_W'(r_x3);

  // Sums at full width, then an arithmetic halving (floor).
  assign w_f1_sum = w_x0e - w_x1e - w_x2e + w_x3e;
  assign w_f2_sum = (w_x1e <<< 1) + w_x1e - w_x0e - w_x2e - w_x3e;
  assign w_f1     = ACC_W'(w_f1_sum >>> 1);
  assign w_f2     = ACC_W'(w_f2_sum >>> 1);
  assign w_f3     = ACC_W'(r_x2);

  // The interval is always non-negative; its top bit carries no information.
  assign w_u         = {1'b0, uk[FRAC_W-1:0]};
  assign w_uk_unused = uk[UK_W-1];

  // Stage 1: capture coefficients and interval on the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f1 <= '0;
      r_f2 <= '0;
      r_f3 <= '0;
      r_u1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= strobe_flag;
      if (strobe_flag) begin
        r_f1 <= w_f1;
        r_f2 <= w_f2;
        r_f3 <= w_f3;
        r_u1 <= w_u;
      end
    end
  end

  // Stage 2: p1 = f1*u + f2.
  farrow_mac u_mac_p1 (
    .clk (clk),
    .rst (rst),
    .i_a (r_f1),
    .i_u (r_u1),
    .i_b (r_f2),
    .o_y (w_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f3_2 <= '0;
      r_u2   <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_f3_2 <= r_f3;
      r_u2   <= r_u1;
      r_v2   <= r_v1;
    end
  end

  // Stage 3: p2 = p1*u + f3.
  farrow_mac u_mac_p2 (
    .clk (clk),
    .rst (rst),
    .i_a (w_p1),
    .i_u (r_u2),
    .i_b (r_f3_2),
    .o_y (w_p2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3 <= 1'b0;
    end else begin
      r_v3 <= r_v2;
    end
  end

  // Stage 4: saturate; the output holds between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interp_out   <= '0;
      interp_valid <= 1'b0;
    end else begin
      interp_valid <= r_v3;
      if (r_v3) begin
        interp_out <= sat_data(w_p2);
      end
    end
  end

endmodule

// File: tb/tb_farrow_interp.sv
// Self-checking bench for farrow_interp: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against an arithmetic model.
module tb_farrow_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        strobe_flag;
  logic [15:0] uk;
  logic [15:0] interp_out;
  logic        interp_valid;

  always #5 clk = ~clk;

  farrow_interp dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .strobe_flag  (strobe_flag),
    .uk           (uk),
    .interp_out   (interp_out),
    .interp_valid (interp_valid)
  );

  typedef struct {
    int due;
    int val;
  } exp_t;

  typedef struct {
    int x3;
    int x2;
    int x1;
    int x0;
    int ukv;
    int exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   n        = 0;
  int   last_out = 0;
  int   hist[4];
  exp_t q[$];
  vec_t vecs[8];

  function automatic void chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & 262143;
    if (m >= 131072) m = m - 262144;
    return m;
  endfunction

  // Parabolic Farrow value from four taps and an interval, straight from the formula.
  function automatic int model_out(input int x0, input int x1, input int x2, input int x3,
                                   input int ukv);
    longint f1, f2, f3, u, p1, p2;
    u  = longint'(ukv % 32768);
    f1 = wrap_acc(longint'(x0 - x1 - x2 + x3) >>> 1);
    f2 = wrap_acc(longint'(3 * x1 - x0 - x2 - x3) >>> 1);
    f3 = longint'(x2);
    p1 = wrap_acc(((f1 * u) >>> 15) + f2);
    p2 = wrap_acc(((p1 * u) >>> 15) + f3);
    if (p2 > 32767) return 32767;
    if (p2 < -32768) return -32768;
    return int'(p2);
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    last_out = 0;
  endfunction

  // One clock: drive inputs, advance, then compare outputs against the model.
  task automatic tick(input int d, input bit s, input int ukv);
    exp_t e;
    din         = d[15:0];
    strobe_flag = s;
    uk          = ukv[15:0];
    if (s) begin
      e.due = n + 4;
      e.val = model_out(hist[0], hist[1], hist[2], hist[3], ukv);
      q.push_back(e);
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = d;
    @(posedge clk);
    #1;
    n++;
    if (q.size() > 0 && q[0].due == n) begin
      chk($sformatf("valid_c%0d", n), longint'(interp_valid), 1);
      chk($sformatf("out_c%0d", n), longint'($signed(interp_out)), longint'(q[0].val));
      last_out = q[0].val;
      void'(q.pop_front());
    end else begin
      chk($sformatf("novalid_c%0d", n), longint'(interp_valid), 0);
      chk($sformatf("hold_c%0d", n), longint'($signed(interp_out)), longint'(last_out));
    end
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    strobe_flag = 1'b0;
    din         = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out", longint'($signed(interp_out)), 0);
    chk("rst_valid", longint'(interp_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst         = 1'b1;
    din         = '0;
    strobe_flag = 1'b0;
    uk          = '0;
    model_reset();
    #2;
    chk("init_out", longint'($signed(interp_out)), 0);
    chk("init_valid", longint'(interp_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Strobe right after reset sees zero-filled taps.
    tick(1000, 1'b1, 'h4000);
    tick(2000, 1'b1, 'h2000);
    for (int i = 0; i < 5; i++) tick(0, 1'b0, 0);

    vecs[0] = '{1000, 1000, 1000, 1000, 'h2A00, 1000};
    vecs[1] = '{0, 100, 200, 300, 'h4000, 150};
    vecs[2] = '{0, 100, 200, 300, 'h0000, 100};
    vecs[3] = '{32767, -32768, -32768, 32767, 'h4000, -32768};
    vecs[4] = '{0, 100, 200, 300, 'hC000, 150};
    vecs[5] = '{-32768, 32767, 32767, -32768, 'h4000, 32767};
    vecs[6] = '{-5000, -5000, -5000, -5000, 'h7FFF, -5000};
    vecs[7] = '{0, 100, 200, 300, 'h7FFF, 199};

    foreach (vecs[i]) begin
      tick(vecs[i].x3, 1'b0, 0);
      tick(vecs[i].x2, 1'b0, 0);
      tick(vecs[i].x1, 1'b0, 0);
      tick(vecs[i].x0, 1'b0, 0);
      tick(vecs[i].x0, 1'b1, vecs[i].ukv);
      for (int k = 0; k < 3; k++) tick(vecs[i].x0, 1'b0, 0);
      chk($sformatf("vec%0d_valid", i), longint'(interp_valid), 1);
      chk($sformatf("vec%0d_out", i), longint'($signed(interp_out)), longint'(vecs[i].exp));
    end

    // Three back-to-back strobes on a ramp.
    for (int i = 0; i < 4; i++) tick(i * 100, 1'b0, 0);
    tick(400, 1'b1, 'h4000);
    tick(500, 1'b1, 'h4000);
    tick(600, 1'b1, 'h4000);
    tick(700, 1'b0, 0);
    chk("b2b_v0", longint'(interp_valid), 1);
    chk("b2b_o0", longint'($signed(interp_out)), 150);
    tick(800, 1'b0, 0);
    chk("b2b_v1", longint'(interp_valid), 1);
    chk("b2b_o1", longint'($signed(interp_out)), 250);
    tick(900, 1'b0, 0);
    chk("b2b_v2", longint'(interp_valid), 1);
    chk("b2b_o2", longint'($signed(interp_out)), 350);
    tick(1000, 1'b0, 0);
    chk("b2b_end", longint'(interp_valid), 0);

    // Reset one cycle after a strobe discards it.
    tick(1234, 1'b1, 'h1000);
    tick(1234, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) tick(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) tick(i * 100, 1'b0, 0);
    tick(300, 1'b1, 'h4000);
    for (int k = 0; k < 3; k++) tick(300, 1'b0, 0);
    chk("post_rst_valid", longint'(interp_valid), 1);
    chk("post_rst_out", longint'($signed(interp_out)), 150);

    // Random traffic, biased toward full-scale samples to reach saturation.
    for (int i = 0; i < 400; i++) begin
      int d;
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) d = 32767;
      else if (sel == 1) d = -32768;
      else d = int'($urandom_range(0, 65535)) - 32768;
      tick(d, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 65535)));
    end
    for (int i = 0; i < 6; i++) tick(0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/farrow_interp.md
FARROW_INTERP -- requirements
Module: farrow_interp

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, 16, sample width, signed Q1.15.
REQ-003 Parameter FRAC_W, 15, fractional bits of uk.
REQ-004 Parameter ACC_W, 18, internal signed accumulator width.
REQ-005 clk  input  1  system clock; one input sample per clock.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 din  input  16  signed baseband sample, Q1.15, valid every clock.
REQ-008 strobe_flag  input  1  NCO interpolation strobe, registered, single-cycle pulses.
REQ-009 uk  input  16  fractional interval, unsigned, low 15 bits fraction, range [0,1); sampled only with strobe_flag.
REQ-010 interp_out  output  16  interpolated sample, signed Q1.15, saturated.
REQ-011 interp_valid  output  1  one-cycle pulse qualifying interp_out.

Function
REQ-012 Delay line: every clock x0<=din, x1<=x0, x2<=x1, x3<=x2; x0 is newest.
REQ-013 Filter: piecewise-parabolic Farrow, alpha=0.5: y = (f1*u + f2)*u + f3.
REQ-014 f1 = (x0 - x1 - x2 + x3) >>> 1; f2 = (3*x1 - x0 - x2 - x3) >>> 1; f3 = x2; sums formed at full width before shift; >>> is arithmetic (floor).
REQ-015 u = {1'b0, uk[14:0]} as 17-bit signed; uk[15] ignored.
REQ-016 Stage 1 (edge where strobe_flag=1): register f1, f2, f3 (ACC_W signed), u, valid1; x0..x3 used are pre-edge contents.
REQ-017 Stage 2: p1 = ((f1*u) >>> FRAC_W) + f2, ACC_W signed; f3, u, valid delayed.
REQ-018 Stage 3: p2 = ((p1*u) >>> FRAC_W) + f3, ACC_W signed; valid delayed.
REQ-019 Stage 4: interp_out <= p2 saturated to [-32768, 32767]; interp_valid <= valid3.
REQ-020 Latency: strobe_flag high in cycle k => interp_valid high in cycle k+4, exactly one cycle per strobe.
REQ-021 Fully pipelined: strobes in consecutive cycles SHALL each produce a result, in order, no loss.
REQ-022 interp_out SHALL hold its last value while interp_valid is low.
REQ-023 Products are full width (ACC_W+17 bits); no intermediate overflow for any input.
REQ-024 strobe_flag during the first 3 cycles after reset SHALL use zero-filled delay-line entries; no special handling.

Reset
REQ-025 rst high SHALL immediately clear x0..x3, all pipeline registers, valid flags, interp_out=0, interp_valid=0.
REQ-026 Reset mid-operation SHALL discard all in-flight strobes; no interp_valid pulse for them after release.
REQ-027 First strobe sampled after rst release is processed normally.

Structure
REQ-028 DATA_W, FRAC_W, ACC_W and the saturation limits SHALL live in shared package qpsk_pkg.
REQ-029 The multiply-shift-add step (a*u >>> FRAC_W + b) SHALL be a sub-module farrow_mac, instantiated twice (stages 2 and 3), each with one output register.

Verification
REQ-030 din constant 1000, strobe with uk=0x2A00 -> interp_out=1000 four cycles later.
REQ-031 Ramp din=0,100,200,300 (x3..x0), strobe uk=0x4000 -> interp_out=150; same with uk=0 -> 100.
REQ-032 x0=x3=32767, x1=x2=-32768, uk=0x4000 -> internal p2=-49152, interp_out=-32768 (saturated).
REQ-033 Strobes in 3 consecutive cycles on ramp input -> 3 consecutive interp_valid pulses, values in order, each matching REQ-031 arithmetic for its delay-line contents.
REQ-034 Assert rst one cycle after a strobe -> outputs 0 immediately, no interp_valid pulse after release; next strobe yields correct result at k+4.
